// File: rtl/div_pkg.sv
// Shared definitions for the serial excess-3 digit divider: default
// parameters, the controller state encoding and the excess-3 decoder.
package div_pkg;

    localparam int DEF_N_DIG   = 4;
    localparam int DEF_DIV_IDX = 1;
    localparam int DEF_Q_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IN   = 3'd1,
        ST_CONV = 3'd2,
        ST_DIV  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Codes 0011..1100 map to 0..9; any other code is treated as digit 0.
    function automatic logic [3:0] xs3_decode(input logic [3:0] code);
        logic [3:0] digit;
        if (code >= 4'd3 && code <= 4'd12) begin
            digit = code - 4'd3;
        end else begin
            digit = 4'd0;
        end
        return digit;
    endfunction

endpackage

// File: rtl/serial_digit_divider_if.sv
// Digit-in / serial-result-out bus of the serial digit divider.
interface serial_digit_divider_if;

    logic       in_valid;
    logic [3:0] in_data;
    logic       mode;
    logic       out_valid;
    logic       out_data;
    logic       out_err;

    modport master (
        output in_valid, in_data, mode,
        input  out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, mode,
        output out_valid, out_data, out_err
    );

endinterface

// File: rtl/digit_sorter.sv
// N_DIG-entry digit register kept in descending order. Each load inserts
// one decoded digit behind every stored digit that is >= it, so equal
// digits keep their arrival order. A first-digit load restarts the list.
module digit_sorter #(
    parameter int N_DIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_first,
    input  logic [3:0]              i_digit,
    output logic [N_DIG-1:0][3:0]   o_digits
);

    logic [N_DIG-1:0][3:0] r_digits;
    logic [N_DIG-1:0][3:0] w_next;
    logic [N_DIG-1:0]      w_ge;

    // Insertion position: entries >= the new digit stay, the first smaller
    // slot takes the new digit, everything after shifts down by one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch can be inferred.
        w_next = r_digits;
        for (int i = 0; i < N_DIG; i++) begin
            w_ge[i] = (r_digits[i] >= i_digit);
        end
        w_next[0] = w_ge[0] ? r_digits[0] : i_digit;
        for (int i = 1; i < N_DIG; i++) begin
            if (w_ge[i]) begin
                w_next[i] = r_digits[i];
            end else if (w_ge[i-1]) begin
                w_next[i] = i_digit;
            end else begin
                w_next[i] = r_digits[i-1];
            end
        end
    end

    // Digit array register: restart on the first digit, insert otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the digit array is a handful of flops rather than a RAM, so it is cleared by reset like any other state.
            r_digits <= '0;
        end else if (i_load) begin
            // NOTE: non-blocking assignment on all clocked state so every flop samples pre-edge values.
            if (i_first) begin
                r_digits <= {{(N_DIG-1){4'd0}}, i_digit};
            end else begin
                r_digits <= w_next;
            end
        end
    end

    assign o_digits = r_digits;

endmodule

// File: rtl/serial_digit_divider.sv
// Collects N_DIG excess-3 digits, sorts them, builds a decimal dividend
// from all sorted digits except the one at DIV_IDX (the divisor), runs a
// restoring division and shifts the quotient or remainder out MSB first.
module serial_digit_divider
    import div_pkg::*;
#(
    parameter int N_DIG   = DEF_N_DIG,
    parameter int DIV_IDX = DEF_DIV_IDX,
    parameter int Q_W     = DEF_Q_W
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_digit_divider_if.slave bus
);

    localparam int CNT_W = $clog2(Q_W + 1);
    localparam int IDX_W = $clog2(N_DIG);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_next_cnt;
    logic                  w_capture;
    logic                  w_first;
    logic                  r_mode;

    logic [N_DIG-1:0][3:0] w_sorted;
    logic [3:0]            w_digit_in;
    logic [IDX_W-1:0]      w_sel;
    logic [3:0]            w_conv_digit;
    logic [3:0]            w_divisor;
    logic                  w_div_zero;

    logic [Q_W-1:0]        r_acc;
    logic [4:0]            r_rem;
    logic [Q_W-1:0]        w_horner;
    logic [4:0]            w_trial;
    logic                  w_sub;
    logic [4:0]            w_rem_next;
    logic [Q_W-1:0]        w_quo_next;
    logic [Q_W-1:0]        w_result;

    logic [Q_W-1:0]        r_res;
    logic                  r_err;
    logic                  r_out_valid;
    logic                  r_out_data;
    logic                  r_out_err;

    assign w_digit_in = xs3_decode(bus.in_data);

    digit_sorter #(
        .N_DIG (N_DIG)
    ) u_sorter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_capture),
        .i_first  (w_first),
        .i_digit  (w_digit_in),
        .o_digits (w_sorted)
    );

    // Next state, phase counter and digit-capture strobes.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + CNT_W'(1);
        w_capture    = 1'b0;
        w_first      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_next_cnt = '0;
                if (bus.in_valid) begin
                    w_capture    = 1'b1;
                    w_first      = 1'b1;
                    w_next_state = ST_IN;
                    w_next_cnt   = CNT_W'(1);
                end
            end
            ST_IN: begin
                if (!bus.in_valid) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_capture = 1'b1;
                    if (r_cnt == CNT_W'(N_DIG - 1)) begin
                        w_next_state = ST_CONV;
                        w_next_cnt   = '0;
                    end
                end
            end
            ST_CONV: begin
                if (r_cnt == CNT_W'(N_DIG - 2)) begin
                    w_next_state = ST_DIV;
                    w_next_cnt   = '0;
                end
            end
            ST_DIV: begin
                if (r_cnt == CNT_W'(Q_W - 1)) begin
                    w_next_state = ST_OUT;
                    w_next_cnt   = '0;
                end
            end
            ST_OUT: begin
                if (r_cnt == CNT_W'(Q_W - 1)) begin
                    if (bus.in_valid) begin
                        w_capture    = 1'b1;
                        w_first      = 1'b1;
                        w_next_state = ST_IN;
                        w_next_cnt   = CNT_W'(1);
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_cnt   = '0;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // State, counter and batch mode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_first) begin
                r_mode <= bus.mode;
            end
        end
    end

    // Sorted-digit index used by the CONV step: walk upward, skipping the divisor slot.
    always_comb begin
        if (int'(r_cnt) < DIV_IDX) begin
            w_sel = IDX_W'(r_cnt);
        end else begin
            w_sel = IDX_W'(r_cnt + CNT_W'(1));
        end
    end

    assign w_conv_digit = w_sorted[w_sel];
    assign w_divisor    = w_sorted[DIV_IDX];
    assign w_div_zero   = (w_divisor == 4'd0);

    // Horner step acc*10 + digit; the dividend always fits Q_W bits.
    assign w_horner = (r_acc << 3) + (r_acc << 1) + {{(Q_W-4){1'b0}}, w_conv_digit};

    // Restoring step: shift the next dividend bit into the partial remainder.
    // A set remainder top bit would already exceed any single-digit divisor.
    assign w_trial    = {r_rem[3:0], r_acc[Q_W-1]};
    assign w_sub      = r_rem[4] | (w_trial >= {1'b0, w_divisor});
    assign w_rem_next = w_sub ? (w_trial - {1'b0, w_divisor}) : w_trial;
    assign w_quo_next = {r_acc[Q_W-2:0], w_sub};
    assign w_result   = w_div_zero ? {Q_W{1'b1}}
                      : (r_mode ? {{(Q_W-5){1'b0}}, w_rem_next} : w_quo_next);

    // Dividend/quotient shift register, partial remainder and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_rem <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else begin
            unique case (r_state)
                ST_CONV: begin
                    r_acc <= w_horner;
                    r_rem <= '0;
                end
                ST_DIV: begin
                    r_acc <= w_quo_next;
                    r_rem <= w_rem_next;
                    if (r_cnt == CNT_W'(Q_W - 1)) begin
                        r_res <= w_result;
                        r_err <= w_div_zero;
                    end
                end
                ST_OUT: begin
                    r_res <= {r_res[Q_W-2:0], 1'b0};
                end
                default: begin
                    r_acc <= '0;
                    r_rem <= '0;
                end
            endcase
        end
    end

    // Registered serial output; everything is forced low outside OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_valid <= (r_state == ST_OUT);
            r_out_data  <= (r_state == ST_OUT) && r_res[Q_W-1];
            r_out_err   <= (r_state == ST_OUT) && r_err;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_serial_digit_divider.sv
// Self-checking bench for serial_digit_divider: directed batches plus
// random batches, compared cycle by cycle against an arithmetic model.
module tb_serial_digit_divider;

    localparam int N_DIG   = 4;
    localparam int DIV_IDX = 1;
    localparam int Q_W     = 10;
    localparam int LAT     = N_DIG + Q_W;

    typedef logic [3:0] codes_t [N_DIG];

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_digit_divider_if bus ();

    serial_digit_divider #(
        .N_DIG   (N_DIG),
        .DIV_IDX (DIV_IDX),
        .Q_W     (Q_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {29'd0, bus.out_valid, bus.out_data, bus.out_err};
    endfunction

    function automatic int xs3(input logic [3:0] c);
        return (c >= 4'd3 && c <= 4'd12) ? int'(c) - 3 : 0;
    endfunction

    // Reference: decode, sort descending, pick divisor, build dividend, divide.
    function automatic logic [Q_W-1:0] ref_result(input codes_t codes, input logic m,
                                                  output logic err);
        int d [N_DIG];
        int t;
        int divisor;
        int dividend;
        for (int i = 0; i < N_DIG; i++) d[i] = xs3(codes[i]);
        for (int i = 0; i < N_DIG; i++) begin
            for (int j = 0; j < N_DIG - 1 - i; j++) begin
                if (d[j] < d[j+1]) begin
                    t = d[j]; d[j] = d[j+1]; d[j+1] = t;
                end
            end
        end
        divisor  = d[DIV_IDX];
        dividend = 0;
        for (int i = 0; i < N_DIG; i++) begin
            if (i != DIV_IDX) dividend = dividend * 10 + d[i];
        end
        err = (divisor == 0);
        if (err) return {Q_W{1'b1}};
        return m ? Q_W'(dividend % divisor) : Q_W'(dividend / divisor);
    endfunction

    task automatic idle_cycles(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", tag, c), outs(), 32'd0);
        end
    endtask

    // Drives digits first..N_DIG-1 on consecutive edges; mode is only meaningful on digit 0.
    task automatic send_digits(input codes_t codes, input logic m, input int first);
        for (int i = first; i < N_DIG; i++) begin
            @(negedge clk);
            check($sformatf("quiet_in d%0d", i), outs(), 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = codes[i];
            bus.mode     = (i == 0) ? m : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 4'($urandom_range(0, 15));
        bus.mode     = 1'($urandom_range(0, 1));
    endtask

    // Checks every cycle from the last capture through the end of output.
    // With chain set, digit 0 of the next batch is driven in the final output cycle.
    task automatic expect_output(input codes_t codes, input logic m, input bit chain,
                                 input codes_t nxt, input logic nm);
        logic [Q_W-1:0] exp_word;
        logic           exp_err;
        logic [2:0]     exp_out;
        int             last;
        exp_word = ref_result(codes, m, exp_err);
        last     = chain ? LAT + Q_W - 1 : LAT + Q_W;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c >= LAT && c < LAT + Q_W) begin
                exp_out = {1'b1, exp_word[Q_W-1-(c-LAT)], exp_err};
            end else begin
                exp_out = 3'b000;
            end
            check($sformatf("out c%0d", c), outs(), {29'd0, exp_out});
            if (chain && c == last) begin
                bus.in_valid = 1'b1;
                bus.in_data  = nxt[0];
                bus.mode     = nm;
            end
        end
    endtask

    codes_t c_ex, c_zero, c_nine, c_inv, cur, nxt;
    logic   cm, nm;
    bit     chain;

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0110;
        bus.mode     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", outs(), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        c_ex   = '{4'b0110, 4'b1010, 4'b0100, 4'b1000};
        c_zero = '{4'b0011, 4'b0011, 4'b0011, 4'b0111};
        c_nine = '{4'b1100, 4'b1100, 4'b1100, 4'b1100};
        c_inv  = '{4'b1111, 4'b0100, 4'b0101, 4'b0110};

        // 731 / 5: quotient then remainder
        send_digits(c_ex, 1'b0, 0);
        expect_output(c_ex, 1'b0, 1'b0, c_ex, 1'b0);
        send_digits(c_ex, 1'b1, 0);
        expect_output(c_ex, 1'b1, 1'b0, c_ex, 1'b0);

        // divisor zero
        send_digits(c_zero, 1'b1, 0);
        expect_output(c_zero, 1'b1, 1'b0, c_zero, 1'b0);

        // short batch is dropped
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1100;
        @(negedge clk);
        bus.in_data  = 4'b0111;
        @(negedge clk);
        bus.in_valid = 1'b0;
        idle_cycles(LAT + Q_W + 4, "discard");

        // 999 / 9, then 310 / 2 back-to-back
        send_digits(c_nine, 1'b0, 0);
        expect_output(c_nine, 1'b0, 1'b1, c_inv, 1'b0);
        send_digits(c_inv, 1'b0, 1);
        expect_output(c_inv, 1'b0, 1'b0, c_inv, 1'b0);

        // reset in the middle of the division
        send_digits(c_inv, 1'b0, 0);
        idle_cycles(8, "pre_abort");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(LAT + Q_W + 4, "abort");
        send_digits(c_ex, 1'b0, 0);
        expect_output(c_ex, 1'b0, 1'b0, c_ex, 1'b0);

        // random batches, some chained
        for (int i = 0; i < N_DIG; i++) cur[i] = 4'($urandom_range(0, 15));
        cm = 1'($urandom_range(0, 1));
        send_digits(cur, cm, 0);
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < N_DIG; i++) nxt[i] = 4'($urandom_range(0, 15));
            nm    = 1'($urandom_range(0, 1));
            chain = (b < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
            expect_output(cur, cm, chain, nxt, nm);
            if (b < 11) send_digits(nxt, nm, chain ? 1 : 0);
            cur = nxt;
            cm  = nm;
        end
        idle_cycles(4, "tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
